lcd_cmd_sequencer: RTL and testbench

- Command scheduler in front of the LCD image-processing controller (4-bit cmd / cmd_valid / busy / done handshake).
- Buffers host commands in a FIFO and waits out the controller's initial image-load busy period.
- Issues one command at a time only when the controller is idle, then tracks its busy pulse to completion.
- Stops permanently after a WRITE (cmd 0) completes and the controller raises done.

---
 rtl/lcd_cmd_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: buffers host commands and issues them one at a time to the
// LCD image controller, following its busy/done handshake until a WRITE finishes.
module lcd_cmd_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AW          = 3,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    host_cmd,
  input  logic          host_push,
  output logic          host_full,
  output logic [AW:0]   fifo_level,
  input  logic          lcd_busy,
  input  logic          lcd_done,
  output logic [3:0]    lcd_cmd,
  output logic          lcd_cmd_valid,
  output logic          seq_busy,
  output logic          seq_done,
  output logic [7:0]    issued_cnt,
  output logic [7:0]    drop_cnt,
  output logic          overflow,
  output logic          ack_timeout
);

  localparam int unsigned CMD_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CMD_W-1:0] CMD_WRITE         = 4'd0;
  localparam logic [CMD_W-1:0] CMD_FIRST_ILLEGAL = 4'd12;

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_ACK       = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [AW:0]      w_level_nxt;
  logic             r_full;
  logic [TW-1:0]    r_ack_cnt;
  logic [CMD_W-1:0] r_lcd_cmd;
  logic             r_lcd_cmd_valid;
  logic             r_seq_busy;
  logic             r_seq_done;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_drop;
  logic             r_overflow;
  logic             r_ack_timeout;

  logic             w_pop;
  logic             w_ack_expire;
  logic             w_is_write;
  logic             w_ack_last;
  logic             w_legal;
  logic             w_push_req;
  logic             w_push_ok;
  logic             w_push_drop;
  logic             w_push_ovf;
  logic [CMD_W-1:0] w_head;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_is_write = (r_lcd_cmd == CMD_WRITE);
  assign w_ack_last = (r_ack_cnt == TW'(ACK_TIMEOUT - 1));

  // Push acceptance: a full FIFO still takes a legal code when the head leaves this cycle.
  assign w_legal     = (host_cmd < CMD_FIRST_ILLEGAL);
  assign w_push_req  = host_push && (r_state != S_DONE);
  assign w_push_ok   = w_push_req && w_legal && (!r_full || w_pop);
  assign w_push_drop = w_push_req && !w_push_ok;
  assign w_push_ovf  = w_push_req && w_legal && !w_push_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; the pop strobe and ack expiry fall out of the transitions.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_ack_expire = 1'b0;
    case (r_state)
      S_INIT: begin
        if (!lcd_busy) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if ((r_level != '0) && !lcd_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_ACK;
      end
      S_ACK: begin
        if (lcd_busy) begin
          w_state_nxt = S_RUN;
        end else if (w_ack_last) begin
          w_ack_expire = 1'b1;
          w_state_nxt  = w_is_write ? S_WAIT_DONE : S_IDLE;
        end
      end
      S_RUN: begin
        if (!lcd_busy) w_state_nxt = w_is_write ? S_WAIT_DONE : S_IDLE;
      end
      S_WAIT_DONE: begin
        if (lcd_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // Occupancy after this cycle's push/pop pair.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push_ok && !w_pop)      w_level_nxt = r_level + (AW+1)'(1);
    else if (!w_push_ok && w_pop) w_level_nxt = r_level - (AW+1)'(1);
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= host_cmd;
  end

  // FIFO pointers, level and full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
    end
  end

  // Counts idle cycles spent in ACK waiting for the controller to go busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_cnt <= '0;
    end else if ((r_state == S_ACK) && !lcd_busy && !w_ack_expire) begin
      r_ack_cnt <= r_ack_cnt + TW'(1);
    end else begin
      r_ack_cnt <= '0;
    end
  end

  // Registered outputs: issue strobe, held command, status, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lcd_cmd       <= '0;
      r_lcd_cmd_valid <= 1'b0;
      r_seq_busy      <= 1'b1;
      r_seq_done      <= 1'b0;
      r_issued        <= '0;
      r_drop          <= '0;
      r_overflow      <= 1'b0;
      r_ack_timeout   <= 1'b0;
    end else begin
      r_lcd_cmd_valid <= w_pop;
      if (w_pop) begin
        r_lcd_cmd <= w_head;
        if (r_issued != {CNT_W{1'b1}}) r_issued <= r_issued + CNT_W'(1);
      end
      r_seq_busy <= (w_state_nxt != S_IDLE);
      if (w_state_nxt == S_DONE) r_seq_done <= 1'b1;
      if (w_push_drop && (r_drop != {CNT_W{1'b1}})) r_drop <= r_drop + CNT_W'(1);
      if (w_push_ovf)   r_overflow    <= 1'b1;
      if (w_ack_expire) r_ack_timeout <= 1'b1;
    end
  end

  assign host_full     = r_full;
  assign fifo_level    = r_level;
  assign lcd_cmd       = r_lcd_cmd;
  assign lcd_cmd_valid = r_lcd_cmd_valid;
  assign seq_busy      = r_seq_busy;
  assign seq_done      = r_seq_done;
  assign issued_cnt    = r_issued;
  assign drop_cnt      = r_drop;
  assign overflow      = r_overflow;
  assign ack_timeout   = r_ack_timeout;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: directed vectors, plan scenarios and random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH       = 8;
  localparam int AW          = 3;
  localparam int ACK_TIMEOUT = 4;

  logic          clk;
  logic          reset;
  logic [3:0]    host_cmd;
  logic          host_push;
  logic          host_full;
  logic [AW:0]   fifo_level;
  logic          lcd_busy;
  logic          lcd_done;
  logic [3:0]    lcd_cmd;
  logic          lcd_cmd_valid;
  logic          seq_busy;
  logic          seq_done;
  logic [7:0]    issued_cnt;
  logic [7:0]    drop_cnt;
  logic          overflow;
  logic          ack_timeout;

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_push(host_push),
    .host_full(host_full), .fifo_level(fifo_level), .lcd_busy(lcd_busy),
    .lcd_done(lcd_done), .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .seq_busy(seq_busy), .seq_done(seq_done), .issued_cnt(issued_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow), .ack_timeout(ack_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int total;
  int bad;

  // ---------------- behavioural reference model ----------------
  int q[$];
  bit m_loaded, m_active, m_issue, m_seen_busy, m_wait_done, m_fin;
  int m_ack, m_last, m_issued, m_drop;
  bit m_ovf, m_tout, m_valid;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_step(input bit rst, input bit push, input int cmd, input bit busy, input bit done);
    bit idle, pop, room;
    int head;
    if (rst) begin
      q.delete();
      m_loaded = 0; m_active = 0; m_issue = 0; m_seen_busy = 0; m_wait_done = 0; m_fin = 0;
      m_ack = 0; m_last = 0; m_issued = 0; m_drop = 0; m_ovf = 0; m_tout = 0; m_valid = 0;
      return;
    end
    idle = m_loaded && !m_active && !m_wait_done && !m_fin;
    pop  = idle && (q.size() > 0) && !busy;
    room = (q.size() < DEPTH) || pop;
    head = 0;
    if (pop) head = q.pop_front();
    if (push && !m_fin) begin
      if (cmd >= 12)  m_drop = sat8(m_drop + 1);
      else if (room)  q.push_back(cmd);
      else begin
        m_drop = sat8(m_drop + 1);
        m_ovf  = 1;
      end
    end
    if (!m_loaded) begin
      if (!busy) m_loaded = 1;
    end else if (m_fin) begin
      // frozen until reset
    end else if (m_wait_done) begin
      if (done) begin m_wait_done = 0; m_fin = 1; end
    end else if (m_active) begin
      if (m_issue) begin
        m_issue = 0;
        m_ack   = 0;
      end else if (!m_seen_busy) begin
        if (busy) m_seen_busy = 1;
        else begin
          m_ack++;
          if (m_ack == ACK_TIMEOUT) begin
            m_tout   = 1;
            m_active = 0;
            if (m_last == 0) m_wait_done = 1;
          end
        end
      end else if (!busy) begin
        m_active = 0;
        if (m_last == 0) m_wait_done = 1;
      end
    end else if (pop) begin
      m_active    = 1;
      m_issue     = 1;
      m_seen_busy = 0;
      m_last      = head;
      m_issued    = sat8(m_issued + 1);
    end
    m_valid = pop;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    bit exp_sbusy;
    exp_sbusy = !(m_loaded && !m_active && !m_wait_done && !m_fin);
    chk("m.lcd_cmd",       32'(lcd_cmd),       32'(m_last));
    chk("m.lcd_cmd_valid", 32'(lcd_cmd_valid), 32'(m_valid));
    chk("m.fifo_level",    32'(fifo_level),    32'(q.size()));
    chk("m.host_full",     32'(host_full),     32'(q.size() == DEPTH));
    chk("m.seq_busy",      32'(seq_busy),      32'(exp_sbusy));
    chk("m.seq_done",      32'(seq_done),      32'(m_fin));
    chk("m.issued_cnt",    32'(issued_cnt),    32'(m_issued));
    chk("m.drop_cnt",      32'(drop_cnt),      32'(m_drop));
    chk("m.overflow",      32'(overflow),      32'(m_ovf));
    chk("m.ack_timeout",   32'(ack_timeout),   32'(m_tout));
  endtask

  int seen[$];
  int exp_q[$];
  int busy_left;
  int busy_len;
  bit busy_wait;

  // One clock: drive away from the edge, advance the model, sample on the falling edge.
  task automatic tick(input bit rst, input bit push, input int cmd, input bit busy, input bit done);
    reset     = rst;
    host_push = push;
    host_cmd  = 4'(cmd);
    lcd_busy  = busy;
    lcd_done  = done;
    @(posedge clk);
    model_step(rst, push, cmd, busy, done);
    @(negedge clk);
    cmp_model();
    if (lcd_cmd_valid === 1'b1) seen.push_back(int'(lcd_cmd));
  endtask

  // Controller stand-in: goes busy the cycle after a strobe, for busy_len cycles.
  task automatic auto_tick(input bit push, input int cmd, input bit done);
    bit b;
    b = 0;
    if (busy_wait) busy_wait = 0;
    else if (busy_left > 0) begin
      b = 1;
      busy_left--;
    end
    tick(0, push, cmd, b, done);
    if (lcd_cmd_valid === 1'b1) begin
      busy_wait = 1;
      busy_left = busy_len;
    end
  endtask

  task automatic ctl_clear();
    busy_wait = 0;
    busy_left = 0;
    seen.delete();
  endtask

  task automatic chk_seen(input string nm);
    chk({nm, ".count"}, 32'(seen.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({nm, ".cmd"}, (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit push; int cmd; bit busy; bit done;
    bit e_valid; int e_cmd; int e_level; bit e_sbusy; int e_issued; int e_drop;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit push, input int cmd, input bit busy,
                              input bit e_valid, input int e_cmd, input int e_level,
                              input bit e_sbusy, input int e_issued, input int e_drop);
    vec_t v;
    v.rst = rst; v.push = push; v.cmd = cmd; v.busy = busy; v.done = 0;
    v.e_valid = e_valid; v.e_cmd = e_cmd; v.e_level = e_level;
    v.e_sbusy = e_sbusy; v.e_issued = e_issued; v.e_drop = e_drop;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int vcnt;
    bit rb, rp, rd;
    int rc, rbl;
    total = 0; bad = 0;
    busy_len = 2; busy_wait = 0; busy_left = 0;
    reset = 1'b1; host_push = 1'b0; host_cmd = '0; lcd_busy = 1'b0; lcd_done = 1'b0;

    //             rst push cmd busy | valid cmd lvl sbusy iss drop
    tbl[0]  = mk(1, 0,  0, 0,   0,  0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0,  0, 0,   0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1,  5, 0,   0,  0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0,  0, 0,   1,  5, 0, 1, 1, 0);
    tbl[4]  = mk(0, 0,  0, 1,   0,  5, 0, 1, 1, 0);
    tbl[5]  = mk(0, 0,  0, 1,   0,  5, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0,  0, 0,   0,  5, 0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 12, 0,   0,  5, 0, 0, 1, 1);
    tbl[8]  = mk(0, 1,  9, 0,   0,  5, 1, 0, 1, 1);
    tbl[9]  = mk(0, 1, 10, 0,   1,  9, 1, 1, 2, 1);
    tbl[10] = mk(0, 0,  0, 0,   0,  9, 1, 1, 2, 1);
    tbl[11] = mk(0, 0,  0, 1,   0,  9, 1, 1, 2, 1);
    tbl[12] = mk(0, 0,  0, 0,   0,  9, 1, 0, 2, 1);
    tbl[13] = mk(0, 0,  0, 0,   1, 10, 0, 1, 3, 1);
    tbl[14] = mk(0, 1, 15, 0,   0, 10, 0, 1, 3, 2);
    tbl[15] = mk(0, 0,  0, 1,   0, 10, 0, 1, 3, 2);

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].rst, tbl[i].push, tbl[i].cmd, tbl[i].busy, tbl[i].done);
      chk("vec.valid",    32'(lcd_cmd_valid), 32'(tbl[i].e_valid));
      chk("vec.lcd_cmd",  32'(lcd_cmd),       32'(tbl[i].e_cmd));
      chk("vec.level",    32'(fifo_level),    32'(tbl[i].e_level));
      chk("vec.seq_busy", 32'(seq_busy),      32'(tbl[i].e_sbusy));
      chk("vec.issued",   32'(issued_cnt),    32'(tbl[i].e_issued));
      chk("vec.drop",     32'(drop_cnt),      32'(tbl[i].e_drop));
    end

    // Startup: controller busy with its image load; the queued command waits.
    tick(1, 0, 0, 1, 0);
    ctl_clear();
    for (int i = 0; i < 70; i++) tick(0, (i == 5), 1, 1, 0);
    chk("startup.no_issue_while_busy", 32'(seen.size()), 32'd0);
    busy_len = 2;
    for (int i = 0; i < 12; i++) auto_tick(0, 0, 0);
    exp_q = {1};
    chk_seen("startup");
    chk("startup.issued", 32'(issued_cnt), 32'd1);

    // Ordering and spacing.
    tick(1, 0, 0, 0, 0);
    ctl_clear();
    auto_tick(0, 0, 0);
    auto_tick(1, 5, 0);
    auto_tick(1, 9, 0);
    auto_tick(1, 10, 0);
    for (int i = 0; i < 25; i++) auto_tick(0, 0, 0);
    exp_q = {5, 9, 10};
    chk_seen("order");
    chk("order.level", 32'(fifo_level), 32'd0);

    // Overflow and illegal code while the controller holds busy.
    tick(1, 0, 0, 1, 0);
    ctl_clear();
    for (int i = 1; i <= 9; i++) tick(0, 1, i, 1, 0);
    tick(0, 1, 13, 1, 0);
    chk("ovf.level",    32'(fifo_level), 32'd8);
    chk("ovf.full",     32'(host_full),  32'd1);
    chk("ovf.overflow", 32'(overflow),   32'd1);
    chk("ovf.drop",     32'(drop_cnt),   32'd2);
    for (int i = 0; i < 60; i++) auto_tick(0, 0, 0);
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8};
    chk_seen("ovf.drain");

    // Full FIFO with a push landing on the pop cycle.
    tick(1, 0, 0, 1, 0);
    ctl_clear();
    for (int i = 1; i <= 8; i++) tick(0, 1, i, 1, 0);
    auto_tick(0, 0, 0);
    auto_tick(1, 3, 0);
    chk("fullpop.valid",    32'(lcd_cmd_valid), 32'd1);
    chk("fullpop.level",    32'(fifo_level),    32'd8);
    chk("fullpop.overflow", 32'(overflow),      32'd0);
    for (int i = 0; i < 70; i++) auto_tick(0, 0, 0);
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8, 3};
    chk_seen("fullpop");

    // Acknowledge timeout: the controller never goes busy.
    tick(1, 0, 0, 0, 0);
    ctl_clear();
    busy_len = 0;
    auto_tick(0, 0, 0);
    auto_tick(1, 7, 0);
    auto_tick(1, 2, 0);
    for (int i = 0; i < 10; i++) auto_tick(0, 0, 0);
    chk("ackto.flag", 32'(ack_timeout), 32'd1);
    exp_q = {7, 2};
    chk_seen("ackto");

    // WRITE terminates the sequence; later commands stay queued forever.
    tick(1, 0, 0, 0, 0);
    ctl_clear();
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    for (int i = 0; i < 65; i++) tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    chk("write.not_done_yet", 32'(seq_done), 32'd0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk("write.seq_done", 32'(seq_done),   32'd1);
    chk("write.issued",   32'(issued_cnt), 32'd1);
    for (int i = 0; i < 3; i++) tick(0, 1, 4, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 14, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0);
    exp_q = {0};
    chk_seen("write.issues");
    chk("write.level_frozen", 32'(fifo_level), 32'd1);
    chk("write.drop",         32'(drop_cnt),   32'd0);
    chk("write.seq_busy",     32'(seq_busy),   32'd1);
    tick(1, 0, 0, 1, 0);
    chk("rst.lcd_cmd",  32'(lcd_cmd),       32'd0);
    chk("rst.valid",    32'(lcd_cmd_valid), 32'd0);
    chk("rst.seq_busy", 32'(seq_busy),      32'd1);
    chk("rst.seq_done", 32'(seq_done),      32'd0);
    chk("rst.issued",   32'(issued_cnt),    32'd0);
    chk("rst.drop",     32'(drop_cnt),      32'd0);
    chk("rst.level",    32'(fifo_level),    32'd0);
    chk("rst.full",     32'(host_full),     32'd0);
    chk("rst.overflow", 32'(overflow),      32'd0);
    chk("rst.ack_to",   32'(ack_timeout),   32'd0);
    tick(0, 1, 3, 1, 0);
    chk("rst.init_holds", 32'(seq_busy),   32'd1);
    chk("rst.init_push",  32'(fifo_level), 32'd1);

    // Counter saturation.
    tick(1, 0, 0, 1, 0);
    for (int i = 0; i < 262; i++) tick(0, 1, 13, 1, 0);
    chk("sat.drop", 32'(drop_cnt), 32'd255);
    tick(1, 0, 0, 0, 0);
    ctl_clear();
    busy_len = 1;
    for (int i = 0; i < 1100; i++) auto_tick(1, 5, 0);
    chk("sat.issued", 32'(issued_cnt), 32'd255);

    // Random traffic against the model.
    tick(1, 0, 0, 0, 0);
    rbl = 0;
    vcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rbl == 0 && $urandom_range(0, 3) == 0) rbl = $urandom_range(1, 8);
      rb = (rbl > 0);
      if (rbl > 0) rbl--;
      rp = ($urandom_range(0, 1) == 0);
      rc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 15);
      rd = ($urandom_range(0, 9) == 0);
      tick(($urandom_range(0, 249) == 0), rp, rc, rb, rd);
      if (lcd_cmd_valid === 1'b1) vcnt++;
    end
    chk("rand.some_issues", 32'(vcnt > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
